mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_if.sv | 49 ++++
 rtl/mem_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: the cache<->memory bus (A2/D2/C2).
//
// D2 and C2 are shared and may be driven by either side. Each side has its own
// value and output enable; the resolved c2/d2 nets are what both ends observe.
// When nobody drives, the resolved value reads as 0, so an undriven C2 looks
// like NOP. A2 is only ever driven by the cache.
//
// Signals:
//   a2          line address (cache)
//   c2_m/_oe    command and enable from the cache
//   d2_m/_oe    write data and enable from the cache
//   c2_s/_oe    response and enable from the memory
//   d2_s/_oe    read data and enable from the memory
//   c2, d2      resolved bus values
//   contention  both sides enabled on the same net
interface mem_ctrl_if #(
    parameter int ADDR2_W = 10,
    parameter int DATA_W  = 16
);
    logic [ADDR2_W-1:0] a2;

    logic [1:0]         c2_m;
    logic               c2_m_oe;
    logic [DATA_W-1:0]  d2_m;
    logic               d2_m_oe;

    logic [1:0]         c2_s;
    logic               c2_s_oe;
    logic [DATA_W-1:0]  d2_s;
    logic               d2_s_oe;

    logic [1:0]         c2;
    logic [DATA_W-1:0]  d2;
    logic               contention;

    assign c2 = c2_s_oe ? c2_s : (c2_m_oe ? c2_m : 2'b00);
    assign d2 = d2_s_oe ? d2_s : (d2_m_oe ? d2_m : '0);
    assign contention = (c2_s_oe & c2_m_oe) | (d2_s_oe & d2_m_oe);

    modport master (
        output a2, c2_m, c2_m_oe, d2_m, d2_m_oe,
        input  c2, d2
    );

    modport slave (
        input  a2, c2, d2,
        output c2_s, c2_s_oe, d2_s, d2_s_oe
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory model behind the L1 cache.
//
// Serves whole-line reads and writes over the shared A2/D2/C2 bus with a fixed
// latency of MEM_DELAY cycles from request sample to first response. Holds
// 2^ADDR2_W lines of LINE_BYTES bytes; a line travels as BEATS little-endian
// beats of BUS_BYTES bytes each.
//
// Ports:
//   clk     clock, all sampling on the rising edge
//   rst     asynchronous, active-high; aborts any transfer, keeps the array
//   m_dump  at a rising edge, print every line (address + bytes ascending)
//   bus     slave side of mem_ctrl_if
//
// Build option: MEM_RANDOM_INIT_EN selects pseudo-random initial contents
// seeded by SEED; without it byte i holds i[7:0]. Reset never reloads them.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | bus released, waiting for READ_LINE / WRITE_LINE
// S_READ_WAIT  | read accepted, driving NOP until the latency expires
// S_READ_SEND  | driving RESPONSE and the line beats
// S_WRITE_RECV | sampling write beats 1..BEATS-1 into the line buffer
// S_WRITE_WAIT | driving NOP until the latency expires, then commit
// S_RESP       | one-cycle RESPONSE acknowledging the write
module mem_ctrl #(
    parameter int LINE_BYTES = 16,
    parameter int BUS_BYTES  = 2,
    parameter int ADDR2_W    = 10,
    parameter int MEM_DELAY  = 100,
    parameter int SEED       = 225526
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      m_dump,
    mem_ctrl_if.slave bus
);
    localparam int DATA_W = 8 * BUS_BYTES;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int DEPTH  = 1 << ADDR2_W;
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam int CNT_W  = $clog2(MEM_DELAY + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] BEAT_END   = BEAT_W'(BEATS);
    // Read: loaded at the request edge, expires MEM_DELAY edges later.
    localparam logic [CNT_W-1:0]  READ_LOAD  = CNT_W'(MEM_DELAY - 1);
    // Write: loaded at the last beat edge (BEATS-1 after the request).
    localparam logic [CNT_W-1:0]  WRITE_LOAD = CNT_W'(MEM_DELAY - BEATS);

    localparam logic [1:0] C_NOP   = 2'd0;
    localparam logic [1:0] C_RESP  = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_WRITE = 2'd3;

    if (MEM_DELAY < BEATS + 1 || SEED < 0 || LINE_BYTES % BUS_BYTES != 0)
    begin : g_bad_param
        $error("mem_ctrl: MEM_DELAY must be >= BEATS+1, SEED >= 0, LINE_BYTES a multiple of BUS_BYTES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_READ_SEND,
        S_WRITE_RECV,
        S_WRITE_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BEAT_W-1:0]  beat;
    logic [ADDR2_W-1:0] addr;
    logic [LINE_W-1:0]  line_buf;
    logic [1:0]         c2_out;
    logic               c2_oe;
    logic [DATA_W-1:0]  d2_out;
    logic               d2_oe;
    logic [31:0]        read_count;
    logic [31:0]        write_count;
    logic               commit;

    logic [LINE_W-1:0]  mem [DEPTH];

    assign bus.c2_s    = c2_out;
    assign bus.c2_s_oe = c2_oe;
    assign bus.d2_s    = d2_out;
    assign bus.d2_s_oe = d2_oe;

    assign commit = (state == S_WRITE_WAIT) && (cnt == '0);

    function automatic logic [31:0] get_reads();
        return read_count;
    endfunction

    function automatic logic [31:0] get_writes();
        return write_count;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            beat        <= '0;
            addr        <= '0;
            line_buf    <= '0;
            c2_out      <= C_NOP;
            c2_oe       <= 1'b0;
            d2_out      <= '0;
            d2_oe       <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Cache owns the bus on the request edge; take it from the next one.
                    if (bus.c2 == C_READ) begin
                        addr       <= bus.a2;
                        cnt        <= READ_LOAD;
                        read_count <= read_count + 32'd1;
                        state      <= S_READ_WAIT;
                    end else if (bus.c2 == C_WRITE) begin
                        addr                  <= bus.a2;
                        line_buf[DATA_W-1:0]  <= bus.d2;
                        beat                  <= BEAT_W'(1);
                        write_count           <= write_count + 32'd1;
                        state                 <= S_WRITE_RECV;
                    end
                end

                S_READ_WAIT: begin
                    c2_oe <= 1'b1;
                    if (cnt == '0) begin
                        line_buf <= mem[addr];
                        d2_out   <= mem[addr][DATA_W-1:0];
                        d2_oe    <= 1'b1;
                        c2_out   <= C_RESP;
                        beat     <= BEAT_W'(1);
                        state    <= S_READ_SEND;
                    end else begin
                        c2_out <= C_NOP;
                        cnt    <= cnt - CNT_W'(1);
                    end
                end

                S_READ_SEND: begin
                    if (beat == BEAT_END) begin
                        c2_out <= C_NOP;
                        c2_oe  <= 1'b0;
                        d2_oe  <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        d2_out <= line_buf[int'(beat) * DATA_W +: DATA_W];
                        beat   <= beat + BEAT_W'(1);
                    end
                end

                S_WRITE_RECV: begin
                    // C2 is expected to hold WRITE_LINE here; it is not re-checked.
                    line_buf[int'(beat) * DATA_W +: DATA_W] <= bus.d2;
                    if (beat == LAST_BEAT) begin
                        cnt   <= WRITE_LOAD;
                        state <= S_WRITE_WAIT;
                    end else begin
                        beat <= beat + BEAT_W'(1);
                    end
                end

                S_WRITE_WAIT: begin
                    c2_oe <= 1'b1;
                    if (cnt == '0) begin
                        c2_out <= C_RESP;
                        state  <= S_RESP;
                    end else begin
                        c2_out <= C_NOP;
                        cnt    <= cnt - CNT_W'(1);
                    end
                end

                S_RESP: begin
                    c2_out <= C_NOP;
                    c2_oe  <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    c2_oe <= 1'b0;
                    d2_oe <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The array only changes on a completed write; an aborted write never gets here.
    always @(posedge clk) begin
        if (commit) begin
            mem[addr] <= line_buf;
        end
    end

`ifndef SYNTHESIS
    initial begin : init_contents
`ifdef MEM_RANDOM_INIT_EN
        int seed;
        seed = SEED;
        for (int ln = 0; ln < DEPTH; ln++) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                mem[ln][b*8 +: 8] = 8'($random(seed) & 32'hFF);
            end
        end
`else
        for (int ln = 0; ln < DEPTH; ln++) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                mem[ln][b*8 +: 8] = 8'(ln * LINE_BYTES + b);
            end
        end
`endif
    end

    always @(posedge clk) begin
        if (m_dump) begin
            for (int ln = 0; ln < DEPTH; ln++) begin
                $write("%03h:", ln);
                for (int b = 0; b < LINE_BYTES; b++) begin
                    $write(" %02h", mem[ln][b*8 +: 8]);
                end
                $write("\n");
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
    localparam int LINE_BYTES = 16;
    localparam int BUS_BYTES  = 2;
    localparam int ADDR2_W    = 10;
    localparam int MEM_DELAY  = 100;
    localparam int SEED       = 225526;
    localparam int BEATS      = LINE_BYTES / BUS_BYTES;
    localparam int DATA_W     = 8 * BUS_BYTES;

    localparam logic [1:0] C_NOP   = 2'd0;
    localparam logic [1:0] C_RESP  = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_WRITE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_dump = 1'b0;

    mem_ctrl_if #(.ADDR2_W(ADDR2_W), .DATA_W(DATA_W)) bus ();

    mem_ctrl #(
        .LINE_BYTES(LINE_BYTES),
        .BUS_BYTES (BUS_BYTES),
        .ADDR2_W   (ADDR2_W),
        .MEM_DELAY (MEM_DELAY),
        .SEED      (SEED)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .m_dump(m_dump),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference: byte-addressed backing store plus request counters.
    byte unsigned ref_mem [LINE_BYTES << ADDR2_W];
    int unsigned  ref_reads  = 0;
    int unsigned  ref_writes = 0;

    initial begin : ref_init
`ifdef MEM_RANDOM_INIT_EN
        int seed;
        seed = SEED;
        for (int i = 0; i < (LINE_BYTES << ADDR2_W); i++) ref_mem[i] = 8'($random(seed) & 32'hFF);
`else
        for (int i = 0; i < (LINE_BYTES << ADDR2_W); i++) ref_mem[i] = 8'(i);
`endif
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: observed no end of test, expected end before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {contention, c2 enable, d2 enable, resolved c2, resolved d2}
    function automatic logic [31:0] bus_view();
        return {11'b0, bus.contention, bus.c2_s_oe, bus.d2_s_oe, bus.c2, bus.d2};
    endfunction

    function automatic logic [31:0] bus_exp(input bit cont, input bit c_oe, input bit d_oe,
                                            input logic [1:0] c, input logic [15:0] d);
        return {11'b0, cont, c_oe, d_oe, c, d};
    endfunction

    function automatic logic [15:0] ref_beat(input int a, input int k);
        return {ref_mem[a*LINE_BYTES + 2*k + 1], ref_mem[a*LINE_BYTES + 2*k]};
    endfunction

    task automatic release_cache();
        bus.c2_m    = C_NOP;
        bus.c2_m_oe = 1'b0;
        bus.d2_m    = 16'($urandom);
        bus.d2_m_oe = 1'b0;
        bus.a2      = ADDR2_W'($urandom);
    endtask

    task automatic abort_with_reset(input string tag);
        m_dump = 1'b0;
        release_cache();
        rst = 1'b1;
        #1;
        check(tag, {30'b0, bus.c2_s_oe, bus.d2_s_oe}, 32'd0);
        ref_reads  = 0;
        ref_writes = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after a falling edge; the next rising edge is E0.
    task automatic read_line(input int a, input int busy_at, input int reset_at, input int dump_at);
        logic [31:0] exp;
        bus.a2      = ADDR2_W'(a);
        bus.c2_m    = C_READ;
        bus.c2_m_oe = 1'b1;
        bus.d2_m_oe = 1'b0;
        ref_reads++;
        for (int n = 0; n <= MEM_DELAY + BEATS; n++) begin
            @(negedge clk);
            if (n == 0) release_cache();
            m_dump = (n == dump_at);
            if (n == busy_at) begin
                bus.c2_m    = C_READ;
                bus.c2_m_oe = 1'b1;
                bus.a2      = ADDR2_W'($urandom);
            end else if (n == busy_at + 1) begin
                release_cache();
            end
            if (n == reset_at) begin
                abort_with_reset($sformatf("read_reset a=%0h n=%0d", a, n));
                return;
            end
            #1;
            if (n == 0)
                exp = bus_exp(1'b0, 1'b0, 1'b0, C_NOP, 16'h0);
            else if (n < MEM_DELAY)
                exp = bus_exp(n == busy_at, 1'b1, 1'b0, C_NOP, 16'h0);
            else if (n < MEM_DELAY + BEATS)
                exp = bus_exp(1'b0, 1'b1, 1'b1, C_RESP, ref_beat(a, n - MEM_DELAY));
            else
                exp = bus_exp(1'b0, 1'b0, 1'b0, C_NOP, 16'h0);
            check($sformatf("read a=%0h n=%0d", a, n), bus_view(), exp);
        end
        m_dump = 1'b0;
        check("read_count", dut.get_reads(), ref_reads);
        check("write_count", dut.get_writes(), ref_writes);
    endtask

    task automatic write_line(input int a, input logic [15:0] beats [BEATS], input int reset_at);
        logic [31:0] exp;
        bus.a2      = ADDR2_W'(a);
        bus.c2_m    = C_WRITE;
        bus.c2_m_oe = 1'b1;
        bus.d2_m    = beats[0];
        bus.d2_m_oe = 1'b1;
        ref_writes++;
        for (int n = 0; n <= MEM_DELAY + 1; n++) begin
            @(negedge clk);
            if (n == 0) bus.a2 = ADDR2_W'($urandom);
            if (n < BEATS - 1) bus.d2_m = beats[n + 1];
            else if (n == BEATS - 1) release_cache();
            if (n == reset_at) begin
                abort_with_reset($sformatf("write_reset a=%0h n=%0d", a, n));
                return;
            end
            #1;
            if (n < BEATS) begin
                check($sformatf("write_quiet a=%0h n=%0d", a, n),
                      {30'b0, bus.c2_s_oe, bus.d2_s_oe}, 32'd0);
            end else begin
                if (n < MEM_DELAY)
                    exp = bus_exp(1'b0, 1'b1, 1'b0, C_NOP, 16'h0);
                else if (n == MEM_DELAY)
                    exp = bus_exp(1'b0, 1'b1, 1'b0, C_RESP, 16'h0);
                else
                    exp = bus_exp(1'b0, 1'b0, 1'b0, C_NOP, 16'h0);
                check($sformatf("write a=%0h n=%0d", a, n), bus_view(), exp);
            end
        end
        for (int k = 0; k < BEATS; k++) begin
            ref_mem[a*LINE_BYTES + 2*k]     = beats[k][7:0];
            ref_mem[a*LINE_BYTES + 2*k + 1] = beats[k][15:8];
        end
        check("read_count", dut.get_reads(), ref_reads);
        check("write_count", dut.get_writes(), ref_writes);
    endtask

    initial begin : main
        logic [15:0] beats [BEATS];
        int a;
        int gap;

        release_cache();
        repeat (2) @(negedge clk);
        #1;
        check("reset_bus", {30'b0, bus.c2_s_oe, bus.d2_s_oe}, 32'd0);
        check("reset_reads", dut.get_reads(), 32'd0);
        check("reset_writes", dut.get_writes(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain read, then a back-to-back read on the very next allowed edge.
        read_line(5, -1, -1, -1);
        read_line(6, -1, -1, -1);

        // Write then read of the top line with fresh counters.
        abort_with_reset("reset_before_wr");
        for (int k = 0; k < BEATS; k++) beats[k] = 16'hA000 + 16'(k);
        write_line(10'h3FF, beats, -1);
        read_line(10'h3FF, -1, -1, -1);

        // Request while busy is ignored; a dump mid-read does not disturb timing.
        read_line(10'h012, 50, -1, 30);

        // Reset during the write beats: nothing committed.
        for (int k = 0; k < BEATS; k++) beats[k] = 16'($urandom);
        write_line(10'h020, beats, 5);
        read_line(10'h020, -1, -1, -1);

        // Reset while read data is on the bus, then a normal read.
        read_line(10'h021, -1, 103, -1);
        read_line(10'h022, -1, -1, -1);

        // Random mix over a small address window so reads hit earlier writes.
        for (int t = 0; t < 14; t++) begin
            a   = 10'h100 + $urandom_range(0, 3);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < BEATS; k++) beats[k] = 16'($urandom);
                write_line(a, beats, -1);
            end else begin
                read_line(a, -1, -1, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
